adain_var_norm_accum: RTL and testbench

- Streaming sum-of-squares accumulator for the AdaIN variance path. It sits directly upstream of the left barrel shifter.
- Squares each signed feature sample and accumulates it over one channel frame (terminated by s_last).
- After the frame, computes the leading-zero count of the accumulator and clamps it to MAX_SHIFT.
- Presents the accumulator value and shift amount on a valid/ready output. m_acc/m_shift wire straight into the shifter's in/shift_amt.

---
 rtl/adain_var_norm_accum.sv | 116 +++++++++++
 tb/tb_adain_var_norm_accum.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/adain_var_norm_accum.sv
// Sum-of-squares accumulator for the AdaIN variance path: squares each sample over a frame,
// then presents the saturated sum and a clamped leading-zero normalisation shift.
module adain_var_norm_accum #(
  parameter  int DATA_W    = 16,
  parameter  int WIDTH     = 48,
  parameter  int MAX_SHIFT = 15,
  parameter  int CNT_W     = 16,
  localparam int SH_W      = $clog2(MAX_SHIFT + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic signed [DATA_W-1:0] s_data,
  input  logic                     s_last,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic        [WIDTH-1:0]  m_acc,
  output logic        [SH_W-1:0]   m_shift,
  output logic        [CNT_W-1:0]  m_count,
  output logic                     m_sat
);

  typedef enum logic [1:0] {ACCUM, NORM, OUT} state_t;

  state_t state, state_next;

  logic        [WIDTH-1:0]    acc;
  logic        [CNT_W-1:0]    count;
  logic                       sat;
  logic signed [2*DATA_W-1:0] square;
  logic        [WIDTH:0]      sum;
  logic                       take;

  function automatic logic [WIDTH-1:0] sat_acc(input logic [WIDTH:0] s);
    return s[WIDTH] ? {WIDTH{1'b1}} : s[WIDTH-1:0];
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  // Leading-zero count clamped to MAX_SHIFT; a zero accumulator clamps as well.
  function automatic logic [SH_W-1:0] norm_shift(input logic [WIDTH-1:0] v);
    int   zeros;
    logic hit;
    zeros = 0;
    hit   = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!hit) begin
        if (v[i]) hit = 1'b1;
        else      zeros++;
      end
    end
    if (zeros > MAX_SHIFT) zeros = MAX_SHIFT;
    return SH_W'(zeros);
  endfunction

  // The signed square is never negative, so its bit pattern zero-extends safely.
  assign square = s_data * s_data;
  assign sum    = {1'b0, acc} + {{(WIDTH + 1 - 2*DATA_W){1'b0}}, square};
  assign take   = s_valid && (state == ACCUM);

  always_comb begin
    state_next = state;
    s_ready    = 1'b0;
    m_valid    = 1'b0;
    case (state)
      ACCUM: begin
        s_ready = 1'b1;
        if (s_valid && s_last) state_next = NORM;
      end
      NORM: state_next = OUT;
      OUT: begin
        m_valid = 1'b1;
        if (m_ready) state_next = ACCUM;
      end
      default: state_next = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ACCUM;
      acc     <= '0;
      count   <= '0;
      sat     <= 1'b0;
      m_acc   <= '0;
      m_shift <= '0;
      m_count <= '0;
      m_sat   <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        ACCUM: if (take) begin
          acc   <= sat_acc(sum);
          count <= sat_inc(count);
          sat   <= sat | sum[WIDTH];
        end
        NORM: begin
          m_acc   <= acc;
          m_shift <= norm_shift(acc);
          m_count <= count;
          m_sat   <= sat;
        end
        OUT: if (m_ready) begin
          acc   <= '0;
          count <= '0;
          sat   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adain_var_norm_accum.sv
// Directed bench for adain_var_norm_accum: default WIDTH=48 instance plus a WIDTH=36 instance
// sharing the same input stream.
module tb_adain_var_norm_accum;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               s_valid = 1'b0;
  logic               s_last = 1'b0;
  logic               m_ready = 1'b1;
  logic signed [15:0] s_data = '0;

  logic        s_ready, m_valid, m_sat;
  logic [47:0] m_acc;
  logic [3:0]  m_shift;
  logic [15:0] m_count;

  logic        s_ready_w, m_valid_w, m_sat_w;
  logic [35:0] m_acc_w;
  logic [3:0]  m_shift_w;
  logic [15:0] m_count_w;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  adain_var_norm_accum dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready), .m_acc(m_acc),
    .m_shift(m_shift), .m_count(m_count), .m_sat(m_sat)
  );

  adain_var_norm_accum #(.WIDTH(36)) dut_w (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready_w), .s_data(s_data),
    .s_last(s_last), .m_valid(m_valid_w), .m_ready(m_ready), .m_acc(m_acc_w),
    .m_shift(m_shift_w), .m_count(m_count_w), .m_sat(m_sat_w)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic signed [15:0] v, input logic last);
    s_valid = 1'b1;
    s_data  = v;
    s_last  = last;
    step();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_n(input logic signed [15:0] v, input int n);
    for (int i = 0; i < n; i++) send(v, i == n - 1);
  endtask

  // Called right after the last handshake, with m_ready high.
  task automatic expect_result(input string tag, input logic [63:0] acc,
                               input logic [63:0] shift, input logic [63:0] cnt,
                               input logic [63:0] sat);
    check({tag, "_norm_valid"}, 64'(m_valid), 64'd0);
    check({tag, "_norm_ready"}, 64'(s_ready), 64'd0);
    step();
    check({tag, "_valid"}, 64'(m_valid), 64'd1);
    check({tag, "_acc"},   64'(m_acc),   acc);
    check({tag, "_shift"}, 64'(m_shift), shift);
    check({tag, "_count"}, 64'(m_count), cnt);
    check({tag, "_sat"},   64'(m_sat),   sat);
    step();
    check({tag, "_valid_drop"}, 64'(m_valid), 64'd0);
    check({tag, "_ready_back"}, 64'(s_ready), 64'd1);
  endtask

  initial begin
    // Reset state
    step();
    step();
    check("rst_valid", 64'(m_valid), 64'd0);
    check("rst_acc",   64'(m_acc),   64'd0);
    check("rst_shift", 64'(m_shift), 64'd0);
    check("rst_count", 64'(m_count), 64'd0);
    check("rst_sat",   64'(m_sat),   64'd0);
    rst_n = 1'b1;
    step();
    check("rst_ready", 64'(s_ready), 64'd1);

    // 1 + 4 + 9 = 14
    send(16'sd1, 1'b0);
    send(16'sd2, 1'b0);
    send(-16'sd3, 1'b1);
    expect_result("t1", 64'd14, 64'd15, 64'd3, 64'd0);

    // Full-scale negative samples
    send_n(-16'sd32768, 8);
    expect_result("t2a", 64'h2_0000_0000, 64'd14, 64'd8, 64'd0);
    send_n(-16'sd32768, 16);
    expect_result("t2b", 64'h4_0000_0000, 64'd13, 64'd16, 64'd0);

    // Single zero sample
    send(16'sd0, 1'b1);
    expect_result("t3", 64'd0, 64'd15, 64'd1, 64'd0);

    // WIDTH=36 saturation and the just-below case
    send_n(-16'sd32768, 64);
    step();
    check("t4a_valid_w", 64'(m_valid_w), 64'd1);
    check("t4a_acc_w",   64'(m_acc_w),   64'hF_FFFF_FFFF);
    check("t4a_sat_w",   64'(m_sat_w),   64'd1);
    check("t4a_shift_w", 64'(m_shift_w), 64'd0);
    check("t4a_count_w", 64'(m_count_w), 64'd64);
    check("t4a_acc",     64'(m_acc),     64'h10_0000_0000);
    check("t4a_shift",   64'(m_shift),   64'd11);
    step();
    check("t4a_ready_w", 64'(s_ready_w), 64'd1);
    send_n(-16'sd32768, 63);
    step();
    check("t4b_acc_w",   64'(m_acc_w),   64'hF_C000_0000);
    check("t4b_sat_w",   64'(m_sat_w),   64'd0);
    check("t4b_shift_w", 64'(m_shift_w), 64'd0);
    check("t4b_count_w", 64'(m_count_w), 64'd63);
    check("t4b_shift",   64'(m_shift),   64'd12);
    step();

    // Backpressure in OUT; stray samples must be ignored
    m_ready = 1'b0;
    send(16'sd5, 1'b0);
    send(-16'sd5, 1'b1);
    step();
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1;
      s_data  = 16'sd1000;
      s_last  = 1'b1;
      check("t5_ready", 64'(s_ready), 64'd0);
      check("t5_valid", 64'(m_valid), 64'd1);
      check("t5_acc",   64'(m_acc),   64'd50);
      check("t5_count", 64'(m_count), 64'd2);
      step();
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    m_ready = 1'b1;
    step();
    check("t5_release_valid", 64'(m_valid), 64'd0);
    check("t5_hold_acc",      64'(m_acc),   64'd50);
    send(16'sd3, 1'b1);
    expect_result("t5_next", 64'd9, 64'd15, 64'd1, 64'd0);

    // Reset mid-frame
    send(16'sd100, 1'b0);
    send(16'sd100, 1'b0);
    send(16'sd100, 1'b0);
    rst_n = 1'b0;
    #1;
    check("t6a_valid", 64'(m_valid), 64'd0);
    step();
    rst_n = 1'b1;
    step();
    send(16'sd7, 1'b1);
    expect_result("t6a_next", 64'd49, 64'd15, 64'd1, 64'd0);

    // Reset while holding a result in OUT
    m_ready = 1'b0;
    send(16'sd2, 1'b1);
    step();
    check("t6b_out_valid", 64'(m_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("t6b_valid", 64'(m_valid), 64'd0);
    check("t6b_acc",   64'(m_acc),   64'd0);
    check("t6b_count", 64'(m_count), 64'd0);
    step();
    rst_n   = 1'b1;
    m_ready = 1'b1;
    step();
    send(16'sd4, 1'b1);
    expect_result("t6b_next", 64'd16, 64'd15, 64'd1, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
